// File: rtl/spectrum_peak_hold_pkg.sv
// Shared types for the tinyspectrum display path: default sizes, bin/magnitude
// types and the peak-hold FSM state encoding.
package tinyspectrum_pkg;

  localparam int TS_NUM_BINS = 8;
  localparam int TS_MAG_W    = 8;
  localparam int TS_BIN_W    = $clog2(TS_NUM_BINS);

  typedef logic [TS_BIN_W-1:0] bin_t;
  typedef logic [TS_MAG_W-1:0] mag_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DECAY = 2'd1,
    SCAN  = 2'd2
  } ph_state_e;

endpackage

// File: rtl/spectrum_peak_hold_if.sv
// Magnitude-in / peak-scan-out signal bundle between the bin core, the
// peak-hold stage and the output mux.
interface spectrum_peak_hold_if
  import tinyspectrum_pkg::*;
#(
  parameter int NUM_BINS = TS_NUM_BINS,
  parameter int MAG_W    = TS_MAG_W
);
  localparam int BIN_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;

  logic             in_valid;
  logic             in_ready;
  logic [BIN_W-1:0] in_bin;
  logic [MAG_W-1:0] in_mag;
  logic             frame_done;
  logic             out_valid;
  logic             out_ready;
  logic [BIN_W-1:0] out_bin;
  logic [MAG_W-1:0] out_mag;
  logic             out_last;
  logic             overrun;

  modport slave (
    input  in_valid, in_bin, in_mag, frame_done, out_ready,
    output in_ready, out_valid, out_bin, out_mag, out_last, overrun
  );

  modport master (
    output in_valid, in_bin, in_mag, frame_done, out_ready,
    input  in_ready, out_valid, out_bin, out_mag, out_last, overrun
  );

endinterface

// File: rtl/spectrum_peak_hold_decay.sv
// One-bin hold/decay step: counts hold down, then subtracts a proportional
// step (at least 1 while nonzero) saturating at zero.
module peak_decay_unit #(
  parameter int MAG_W       = 8,
  parameter int HOLD_W      = 2,
  parameter int DECAY_SHIFT = 2
) (
  input  logic [MAG_W-1:0]  peak_i,
  input  logic [HOLD_W-1:0] hold_i,
  output logic [MAG_W-1:0]  peak_o,
  output logic [HOLD_W-1:0] hold_o
);

  function automatic logic [MAG_W-1:0] decay_step(input logic [MAG_W-1:0] p);
    logic [MAG_W-1:0] s;
    s = p >> DECAY_SHIFT;
    if (s == '0 && p != '0) s = MAG_W'(1);
    return s;
  endfunction

  function automatic logic [MAG_W-1:0] sat_sub(input logic [MAG_W-1:0] a,
                                                input logic [MAG_W-1:0] b);
    return (b > a) ? '0 : a - b;
  endfunction

  always_comb begin
    peak_o = peak_i;
    hold_o = hold_i;
    if (hold_i != '0) hold_o = hold_i - HOLD_W'(1);
    else              peak_o = sat_sub(peak_i, decay_step(peak_i));
  end

endmodule

// File: rtl/spectrum_peak_hold.sv
// Per-bin peak capture with hold-then-decay; on each frame_done the whole
// frame is decayed one bin per cycle and then streamed out bin by bin.
module spectrum_peak_hold
  import tinyspectrum_pkg::*;
#(
  parameter int NUM_BINS    = TS_NUM_BINS,
  parameter int MAG_W       = TS_MAG_W,
  parameter int HOLD_FRAMES = 2,
  parameter int DECAY_SHIFT = 2
) (
  input logic                 clk,
  input logic                 rst,
  spectrum_peak_hold_if.slave sph
);

  localparam int BIN_W  = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam int DEPTH  = 1 << BIN_W;
  localparam int HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam logic [BIN_W-1:0]  LAST_BIN  = BIN_W'(NUM_BINS - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_FRAMES);

  ph_state_e         state_q;
  logic [BIN_W-1:0]  cnt_q;
  logic [MAG_W-1:0]  peak_q [DEPTH];
  logic [HOLD_W-1:0] hold_q [DEPTH];
  logic              out_valid_q;
  logic [BIN_W-1:0]  out_bin_q;
  logic [MAG_W-1:0]  out_mag_q;
  logic              out_last_q;
  logic              overrun_q;

  logic [MAG_W-1:0]  dec_peak_d;
  logic [HOLD_W-1:0] dec_hold_d;
  logic [BIN_W-1:0]  nxt_bin_d;
  logic              wr_en_d;

  assign nxt_bin_d = cnt_q + BIN_W'(1);
  // >= so that an equal magnitude re-arms the hold counter
  assign wr_en_d   = (state_q == IDLE) && sph.in_valid && (sph.in_mag >= peak_q[sph.in_bin]);

  peak_decay_unit #(
    .MAG_W       (MAG_W),
    .HOLD_W      (HOLD_W),
    .DECAY_SHIFT (DECAY_SHIFT)
  ) u_decay (
    .peak_i (peak_q[cnt_q]),
    .hold_i (hold_q[cnt_q]),
    .peak_o (dec_peak_d),
    .hold_o (dec_hold_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_bin_q   <= '0;
      out_mag_q   <= '0;
      out_last_q  <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        peak_q[i] <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      if (sph.frame_done && state_q != IDLE) overrun_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (wr_en_d) begin
            peak_q[sph.in_bin] <= sph.in_mag;
            hold_q[sph.in_bin] <= HOLD_INIT;
          end
          if (sph.frame_done) begin
            state_q <= DECAY;
            cnt_q   <= '0;
          end
        end
        DECAY: begin
          peak_q[cnt_q] <= dec_peak_d;
          hold_q[cnt_q] <= dec_hold_d;
          if (cnt_q == LAST_BIN) begin
            // bin 0 was decayed on an earlier cycle, so its stored peak is final
            state_q     <= SCAN;
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            out_bin_q   <= '0;
            out_mag_q   <= peak_q[0];
            out_last_q  <= (LAST_BIN == '0);
          end else begin
            cnt_q <= nxt_bin_d;
          end
        end
        SCAN: begin
          if (sph.out_ready) begin
            if (out_last_q) begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end else begin
              cnt_q      <= nxt_bin_d;
              out_bin_q  <= nxt_bin_d;
              out_mag_q  <= peak_q[nxt_bin_d];
              out_last_q <= (nxt_bin_d == LAST_BIN);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sph.in_ready  = (state_q == IDLE);
  assign sph.out_valid = out_valid_q;
  assign sph.out_bin   = out_bin_q;
  assign sph.out_mag   = out_mag_q;
  assign sph.out_last  = out_last_q;
  assign sph.overrun   = overrun_q;

endmodule
